hit_or_miss_judge: RTL and testbench

- Consumer end of the one-hot target interface: takes the 8-bit one-hot target produced by the random target generator, arms a round, and watches 8 player buttons for a single press.
- Judges each round as HIT or MISS, keeps saturating hit/miss tallies and drives a result LED pattern.
- Sits between the random target generator and the board's buttons and LEDs.

---
 rtl/hit_or_miss_judge.sv | 157 +++++++++++++++
 tb/tb_hit_or_miss_judge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_or_miss_judge.sv
// rtl/hit_or_miss_judge.sv - one-hot target round judge with hit/miss tallies; optional HOM_STREAK_EN adds streak/best outputs
module hit_or_miss_judge #(
    parameter logic [15:0] WINDOW_CYCLES = 16'd50000,
    parameter logic [15:0] RESULT_CYCLES = 16'd1000,
    parameter int          SCORE_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         target,
    input  logic [7:0]         btn,
    output logic               busy,
    output logic               hit,
    output logic               miss,
    output logic [2:0]         target_idx,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
`ifdef HOM_STREAK_EN
    output logic [SCORE_W-1:0] streak,
    output logic [SCORE_W-1:0] best,
`endif
    output logic [7:0]         led
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    logic [1:0]  state;
    logic [7:0]  btn_q;
    logic [15:0] win_timer;
    logic [15:0] res_timer;
    logic        last_hit;
    logic [2:0]  target_enc;
    logic [7:0]  press;
    logic        decide;
    logic        decide_hit;

    // Encode the one-hot target; anything not exactly one-hot falls back to index 0
    always_comb begin
        logic [3:0] ones;
        logic [2:0] idx;
        ones = 4'd0;
        idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (target[i]) begin
                ones = ones + 4'd1;
                idx  = 3'(i);
            end
        end
        target_enc = (ones == 4'd1) ? idx : 3'd0;
    end

    // Verdict: any rising edge decides the round, a single edge on the target is the only hit;
    // the timeout only fires when no edge arrives in that cycle
    always_comb begin
        press      = btn & ~btn_q;
        decide_hit = (press == (8'b1 << target_idx));
        decide     = (state == ARMED) &&
                     ((press != 8'd0) || (win_timer == WINDOW_CYCLES - 16'd1));
    end

    // Round sequencing, timers, edge register and verdict pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            btn_q      <= 8'd0;
            win_timer  <= 16'd0;
            res_timer  <= 16'd0;
            last_hit   <= 1'b0;
            target_idx <= 3'd0;
            hit        <= 1'b0;
            miss       <= 1'b0;
        end else begin
            btn_q <= btn;
            hit   <= 1'b0;
            miss  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        target_idx <= target_enc;
                        win_timer  <= 16'd0;
                        state      <= ARMED;
                    end
                end
                ARMED: begin
                    if (decide) begin
                        hit       <= decide_hit;
                        miss      <= ~decide_hit;
                        last_hit  <= decide_hit;
                        res_timer <= 16'd0;
                        state     <= RESULT;
                    end else begin
                        win_timer <= win_timer + 16'd1;
                    end
                end
                RESULT: begin
                    if (res_timer == RESULT_CYCLES - 16'd1) begin
                        state <= IDLE;
                    end else begin
                        res_timer <= res_timer + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating tallies, updated on the edge that raises the matching pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            score  <= '0;
            misses <= '0;
        end else if (decide) begin
            if (decide_hit) begin
                if (score != '1) score <= score + SCORE_W'(1);
            end else begin
                if (misses != '1) misses <= misses + SCORE_W'(1);
            end
        end
    end

`ifdef HOM_STREAK_EN
    logic [SCORE_W-1:0] streak_inc;

    // Next streak value on a hit, held at all-ones once full
    always_comb begin
        streak_inc = (streak == '1) ? streak : streak + SCORE_W'(1);
    end

    // Consecutive-hit streak and its running maximum
    always_ff @(posedge clock) begin
        if (reset) begin
            streak <= '0;
            best   <= '0;
        end else if (decide) begin
            if (decide_hit) begin
                streak <= streak_inc;
                if (streak_inc > best) best <= streak_inc;
            end else begin
                streak <= '0;
            end
        end
    end
`endif

    // Status and display derived from the registered state
    always_comb begin
        busy = (state != IDLE);
        case (state)
            ARMED:   led = 8'b1 << target_idx;
            RESULT:  led = last_hit ? 8'hFF : 8'h00;
            default: led = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_hit_or_miss_judge.sv
// tb/tb_hit_or_miss_judge.sv - scoreboard bench for hit_or_miss_judge
module tb_hit_or_miss_judge;

    localparam int W   = 10;
    localparam int R   = 4;
    localparam int SW  = 2;
    localparam int SAT = (1 << SW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    target = 8'h00;
    logic [7:0]    btn = 8'h00;
    logic          busy, hit, miss;
    logic [2:0]    target_idx;
    logic [SW-1:0] score, misses;
    logic [7:0]    led;
`ifdef HOM_STREAK_EN
    logic [SW-1:0] streak, best;
`endif

    hit_or_miss_judge #(
        .WINDOW_CYCLES(16'(W)),
        .RESULT_CYCLES(16'(R)),
        .SCORE_W(SW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .target(target),
        .btn(btn),
        .busy(busy),
        .hit(hit),
        .miss(miss),
        .target_idx(target_idx),
        .score(score),
        .misses(misses),
`ifdef HOM_STREAK_EN
        .streak(streak),
        .best(best),
`endif
        .led(led)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic is_hit;
        int   at;
        int   sc;
        int   ms;
        int   stk;
        int   bst;
    } exp_t;

    exp_t sb[$];
    int m_score = 0, m_miss = 0, m_streak = 0, m_best = 0;
    int last_pulse = 0;

    task automatic push(input logic h, input int at);
        exp_t e;
        if (h) begin
            if (m_score < SAT) m_score++;
            if (m_streak < SAT) m_streak++;
            if (m_streak > m_best) m_best = m_streak;
        end else begin
            if (m_miss < SAT) m_miss++;
            m_streak = 0;
        end
        e.is_hit = h; e.at = at; e.sc = m_score; e.ms = m_miss;
        e.stk = m_streak; e.bst = m_best;
        sb.push_back(e);
    endtask

    function automatic logic [2:0] exp_idx(input logic [7:0] t);
        logic [2:0] idx = 3'd0;
        if ($countones(t) == 1)
            for (int i = 0; i < 8; i++) if (t[i]) idx = 3'(i);
        return idx;
    endfunction

    // Pop the scoreboard whenever the DUT reports a verdict
    always @(negedge clock) begin
        if (!reset && (hit || miss)) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", {30'd0, hit, miss}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("verdict_hit", hit, e.is_hit);
                check("verdict_miss", miss, !e.is_hit);
                check("pulse_cycle", cyc, e.at);
                check("score", score, e.sc);
                check("misses", misses, e.ms);
                check("led_result", led, e.is_hit ? 8'hFF : 8'h00);
`ifdef HOM_STREAK_EN
                check("streak", streak, e.stk);
                check("best", best, e.bst);
`endif
                last_pulse = cyc;
            end
        end
    end

    task automatic arm(input logic [7:0] tgt, output int t_edge);
        @(posedge clock); #1;
        start = 1'b1; target = tgt; t_edge = cyc + 1;
        @(posedge clock); #1;
        start = 1'b0; target = 8'($urandom);
        check("busy_armed", busy, 1);
        check("target_idx", target_idx, exp_idx(tgt));
        check("led_armed", led, 8'b1 << exp_idx(tgt));
    endtask

    task automatic press_after(input int d, input logic [7:0] bits, input logic exp_hit);
        repeat (d) @(posedge clock);
        #1;
        btn = btn | bits;
        push(exp_hit, cyc + 1);
    endtask

    task automatic finish_round();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check("round_end_bound", busy, 0);
        check("result_hold", cyc - last_pulse, R);
        check("missing_pulse", sb.size(), 0);
        check("led_idle", led, 8'h00);
        btn = 8'h00;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic hit_round(input logic [7:0] tgt, input logic [7:0] bits, input logic h);
        int t;
        arm(tgt, t);
        press_after(2, bits, h);
        finish_round();
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_hit", hit, 0);
        check("rst_miss", miss, 0);
        check("rst_idx", target_idx, 0);
        check("rst_score", score, 0);
        check("rst_misses", misses, 0);
        check("rst_led", led, 0);

        // Basic hit after 5 cycles
        arm(8'b0000_1000, t);
        press_after(5, 8'b0000_1000, 1'b1);
        finish_round();

        // Wrong button, then two simultaneous edges including the target
        hit_round(8'b0000_0100, 8'b0100_0000, 1'b0);
        hit_round(8'b0000_0100, 8'b0010_0100, 1'b0);
        check("score_after_misses", score, 1);

        // Pure timeout
        arm(8'h10, t);
        push(1'b0, t + W);
        finish_round();

        // Press in the timeout cycle wins
        arm(8'h10, t);
        press_after(W - 1, 8'h10, 1'b1);
        finish_round();

        // Held button through start with invalid target
        btn = 8'h01;
        arm(8'h00, t);
        repeat (3) @(posedge clock);
        #1;
        btn = 8'h00;
        press_after(1, 8'h01, 1'b1);
        finish_round();

        // Saturation of both tallies
        hit_round(8'h80, 8'h80, 1'b1);
        hit_round(8'h01, 8'h02, 1'b0);
        check("score_sat", score, SAT);
        check("misses_sat", misses, SAT);

        // Reset in ARMED, coinciding with a press
        arm(8'h02, t);
        @(posedge clock); #1;
        reset = 1'b1; btn = 8'h02;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rstarm_busy", busy, 0);
        check("rstarm_score", score, 0);
        check("rstarm_misses", misses, 0);
        check("rstarm_hit", hit, 0);
        check("rstarm_miss", miss, 0);
        m_score = 0; m_miss = 0; m_streak = 0; m_best = 0;
        repeat (3) @(posedge clock);
        #1;
        check("rstarm_nopulse", {hit, miss}, 0);
        btn = 8'h00;
        repeat (2) @(posedge clock);
        #1;

        // Streak sequence: hit, hit, miss, hit
        hit_round(8'h20, 8'h20, 1'b1);
        hit_round(8'h04, 8'h04, 1'b1);
        hit_round(8'h04, 8'h08, 1'b0);
        hit_round(8'h40, 8'h40, 1'b1);
`ifdef HOM_STREAK_EN
        check("final_streak", streak, 1);
        check("final_best", best, 2);
`endif
        check("final_score", score, 3);
        check("final_misses", misses, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
